// File: rtl/month_year_counter.sv
// Month/year calendar stage: advances on end-of-month carries from the day
// counter, supports manual month/year setting, and drives BCD display digits.
module month_year_counter #(
  parameter int YEAR_MIN    = 2000,
  parameter int YEAR_MAX    = 2999,
  parameter int RESET_MONTH = 1,
  parameter int RESET_YEAR  = 2000
) (
  input  logic        clk_1s,
  input  logic        rst,
  input  logic        day_done,
  input  logic        set_enable,
  input  logic        set_sel,
  input  logic        inc,
  input  logic        dec,
  output logic [3:0]  month,
  output logic [11:0] year,
  output logic        is_leap,
  output logic [4:0]  days_in_month,
  output logic [3:0]  month_tens,
  output logic [3:0]  month_units,
  output logic [3:0]  year_thousands,
  output logic [3:0]  year_hundreds,
  output logic [3:0]  year_tens,
  output logic [3:0]  year_units,
  output logic        year_done
);

  localparam logic [11:0] YMIN = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX = 12'(YEAR_MAX);
  localparam logic [3:0]  RMON = 4'(RESET_MONTH);
  localparam logic [11:0] RYR  = 12'(RESET_YEAR);

  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic        year_done_q, year_done_d;
  logic        inc_q, dec_q;
  logic        inc_pulse, dec_pulse;

  assign inc_pulse = inc & ~inc_q;
  assign dec_pulse = dec & ~dec_q;

  // Next-state: run-mode carry rollover, or set-mode button stepping with wrap.
  always_comb begin
    month_d     = month_q;
    year_d      = year_q;
    year_done_d = 1'b0;
    if (!set_enable) begin
      if (day_done) begin
        if (month_q < 4'd12) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d = 4'd1;
          if (year_q < YMAX) begin
            year_d = year_q + 12'd1;
          end else begin
            year_d      = YMIN;
            year_done_d = 1'b1;
          end
        end
      end
    end else if (inc_pulse && !dec_pulse) begin
      if (!set_sel) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
      else          year_d  = (year_q >= YMAX)   ? YMIN : year_q + 12'd1;
    end else if (dec_pulse && !inc_pulse) begin
      if (!set_sel) month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
      else          year_d  = (year_q <= YMIN)  ? YMAX  : year_q - 12'd1;
    end
  end

  // State and button-history registers; reset overrides everything.
  always_ff @(posedge clk_1s) begin
    if (rst) begin
      month_q     <= RMON;
      year_q      <= RYR;
      year_done_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      month_q     <= month_d;
      year_q      <= year_d;
      year_done_q <= year_done_d;
      inc_q       <= inc;
      dec_q       <= dec;
    end
  end

  assign month     = month_q;
  assign year      = year_q;
  assign year_done = year_done_q;

  // Binary-to-BCD by repeated compare/subtract (year < 4096, month < 16).
  logic [11:0] rem;
  logic [3:0]  d_th, d_hu, d_te;
  always_comb begin
    rem  = year_q;
    d_th = 4'd0;
    d_hu = 4'd0;
    d_te = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (rem >= 12'd1000) begin
        rem  = rem - 12'd1000;
        d_th = d_th + 4'd1;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (rem >= 12'd100) begin
        rem  = rem - 12'd100;
        d_hu = d_hu + 4'd1;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (rem >= 12'd10) begin
        rem  = rem - 12'd10;
        d_te = d_te + 4'd1;
      end
    end
  end

  assign year_thousands = d_th;
  assign year_hundreds  = d_hu;
  assign year_tens      = d_te;
  assign year_units     = rem[3:0];

  // Month digits: only 10..12 need a tens digit.
  always_comb begin
    if (month_q >= 4'd10) begin
      month_tens  = 4'd1;
      month_units = month_q - 4'd10;
    end else begin
      month_tens  = 4'd0;
      month_units = month_q;
    end
  end

  // Leap: multiple of 100 is seen via zero tens/units digits; since 100 = 4*25,
  // a multiple of 100 is a multiple of 400 exactly when it is a multiple of 16.
  logic div100;
  assign div100  = (d_te == 4'd0) && (rem[3:0] == 4'd0);
  assign is_leap = div100 ? (year_q[3:0] == 4'd0) : (year_q[1:0] == 2'd0);

  // Month length lookup; unreachable months read as 31.
  always_comb begin
    case (month_q)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = is_leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  end

endmodule

// File: tb/tb_month_year_counter.sv
// Directed bench for month_year_counter with an expectation queue.
module tb_month_year_counter;

  logic        clk_1s = 1'b0;
  logic        rst = 1'b1, day_done = 1'b0, set_enable = 1'b0, set_sel = 1'b0;
  logic        inc = 1'b0, dec = 1'b0;
  logic [3:0]  month, month_tens, month_units;
  logic [11:0] year;
  logic        is_leap, year_done;
  logic [4:0]  days_in_month;
  logic [3:0]  year_thousands, year_hundreds, year_tens, year_units;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string tag;
    int    m;
    int    y;
    int    yd;
  } exp_t;
  exp_t sb[$];

  month_year_counter dut (
    .clk_1s(clk_1s), .rst(rst), .day_done(day_done), .set_enable(set_enable),
    .set_sel(set_sel), .inc(inc), .dec(dec), .month(month), .year(year),
    .is_leap(is_leap), .days_in_month(days_in_month), .month_tens(month_tens),
    .month_units(month_units), .year_thousands(year_thousands),
    .year_hundreds(year_hundreds), .year_tens(year_tens), .year_units(year_units),
    .year_done(year_done)
  );

  always #5 clk_1s = ~clk_1s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_out();
    exp_t e;
    int   lp, dm;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e  = sb.pop_front();
    lp = ((e.y % 400) == 0 || ((e.y % 4) == 0 && (e.y % 100) != 0)) ? 1 : 0;
    if (e.m == 2)                                   dm = lp ? 29 : 28;
    else if (e.m == 4 || e.m == 6 || e.m == 9 || e.m == 11) dm = 30;
    else                                            dm = 31;
    chk({e.tag, ".month"},  32'(month), e.m);
    chk({e.tag, ".year"},   32'(year), e.y);
    chk({e.tag, ".ydone"},  32'(year_done), e.yd);
    chk({e.tag, ".leap"},   32'(is_leap), lp);
    chk({e.tag, ".dim"},    32'(days_in_month), dm);
    chk({e.tag, ".m10"},    32'(month_tens), e.m / 10);
    chk({e.tag, ".m1"},     32'(month_units), e.m % 10);
    chk({e.tag, ".y1000"},  32'(year_thousands), e.y / 1000);
    chk({e.tag, ".y100"},   32'(year_hundreds), (e.y / 100) % 10);
    chk({e.tag, ".y10"},    32'(year_tens), (e.y / 10) % 10);
    chk({e.tag, ".y1"},     32'(year_units), e.y % 10);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then check.
  task automatic cyc(input bit r, input bit se, input bit sl, input bit ic, input bit dc,
                     input bit dd, input int em, input int ey, input int eyd,
                     input string tag);
    exp_t e;
    rst = r; set_enable = se; set_sel = sl; inc = ic; dec = dc; day_done = dd;
    e.tag = tag; e.m = em; e.y = ey; e.yd = eyd;
    sb.push_back(e);
    @(posedge clk_1s);
    #1;
    check_out();
  endtask

  task automatic bump_year(input int m, input int from, input int n);
    for (int i = 1; i <= n; i++) begin
      cyc(0, 1, 1, 1, 0, 0, m, from + i, 0, "yr_inc");
      cyc(0, 1, 1, 0, 0, 0, m, from + i, 0, "yr_rel");
    end
  endtask

  initial begin
    // reset for two cycles
    cyc(1, 0, 0, 0, 0, 0, 1, 2000, 0, "rst0");
    cyc(1, 0, 0, 0, 0, 0, 1, 2000, 0, "rst1");
    chk("rst_leap", 32'(is_leap), 1);
    chk("rst_dim", 32'(days_in_month), 31);
    chk("rst_bcd", {16'd0, year_thousands, year_hundreds, year_tens, year_units}, 32'h2000);

    // set-mode wraps: month 1 -> 12, year 2000 -> 2999, no year_done
    cyc(0, 1, 0, 0, 1, 0, 12, 2000, 0, "mdec_wrap");
    cyc(0, 1, 0, 0, 0, 0, 12, 2000, 0, "mdec_rel");
    cyc(0, 1, 1, 0, 1, 0, 12, 2999, 0, "ydec_wrap");
    cyc(0, 1, 1, 0, 0, 0, 12, 2999, 0, "ydec_rel");

    // millennium wrap in run mode: year_done for exactly one cycle
    cyc(0, 0, 0, 0, 0, 1, 1, 2000, 1, "mill_wrap");
    cyc(0, 0, 0, 0, 0, 0, 1, 2000, 0, "mill_after");
    cyc(0, 0, 0, 0, 0, 0, 1, 2000, 0, "mill_after2");

    // inc edge in run mode does nothing
    cyc(0, 0, 0, 1, 0, 0, 1, 2000, 0, "run_inc");
    cyc(0, 0, 1, 1, 0, 0, 1, 2000, 0, "run_inc_hold");
    cyc(0, 0, 0, 0, 0, 0, 1, 2000, 0, "run_inc_rel");

    // load 12/2023, then run rollover to 1/2024 and 2/2024
    cyc(0, 1, 0, 0, 1, 0, 12, 2000, 0, "load_m12");
    cyc(0, 1, 0, 0, 0, 0, 12, 2000, 0, "load_rel");
    bump_year(12, 2000, 23);
    cyc(0, 0, 0, 0, 0, 1, 1, 2024, 0, "run_roll");
    chk("roll_leap", 32'(is_leap), 1);
    cyc(0, 0, 0, 0, 0, 1, 2, 2024, 0, "run_feb");
    chk("feb2024_dim", 32'(days_in_month), 29);
    cyc(0, 0, 0, 0, 0, 0, 2, 2024, 0, "run_idle");

    // inc held 10 cycles gives a single increment
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0, 0, 3, 2024, 0, "inc_held");
    cyc(0, 1, 0, 0, 0, 0, 3, 2024, 0, "inc_held_rel");

    // simultaneous edges, and day_done dropped in set mode
    cyc(0, 1, 0, 1, 1, 0, 3, 2024, 0, "inc_dec_both");
    cyc(0, 1, 0, 0, 0, 0, 3, 2024, 0, "both_rel");
    cyc(0, 1, 0, 0, 0, 1, 3, 2024, 0, "dd_in_set");
    cyc(0, 0, 0, 0, 0, 0, 3, 2024, 0, "dd_not_queued");

    // leap table
    cyc(0, 1, 0, 0, 1, 0, 2, 2024, 0, "to_feb");
    cyc(0, 1, 0, 0, 0, 0, 2, 2024, 0, "to_feb_rel");
    bump_year(2, 2024, 76);
    chk("y2100_leap", 32'(is_leap), 0);
    chk("y2100_dim", 32'(days_in_month), 28);
    bump_year(2, 2100, 300);
    chk("y2400_leap", 32'(is_leap), 1);
    chk("y2400_dim", 32'(days_in_month), 29);
    cyc(0, 1, 0, 1, 0, 0, 3, 2400, 0, "to_mar");
    cyc(0, 1, 0, 0, 0, 0, 3, 2400, 0, "to_mar_rel");
    cyc(0, 1, 0, 1, 0, 0, 4, 2400, 0, "to_apr");
    chk("apr_dim", 32'(days_in_month), 30);

    // reset mid-setting wins; cleared inc history makes held inc edge again
    cyc(1, 1, 0, 1, 0, 0, 1, 2000, 0, "mid_set_rst");
    chk("mid_rst_m10", 32'(month_tens), 0);
    chk("mid_rst_m1", 32'(month_units), 1);
    cyc(0, 1, 0, 1, 0, 0, 2, 2000, 0, "post_rst_edge");
    cyc(0, 1, 0, 1, 0, 0, 2, 2000, 0, "post_rst_hold");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
